// File: rtl/sram_arb_1p1024x39.sv
`timescale 1ns / 1ps
// sram_arb_1p1024x39
//
// Controller in front of one 1024x39 single-port SRAM (32 data + 7 SECDED bits).
// After reset, and whenever init_req_i is seen while idle, every word is overwritten
// with InitValue. While idle, two requesters (A and B) share the array through a
// round-robin arbiter. The grant is combinational, in the same cycle as the request.
// Read data comes back one cycle after the grant, on the side that issued the read.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   init_req_i           request a full-array clear (only looked at while idle)
//   init_done_o          array cleared and requests being served
//   a_* / b_*            requester A / B: req, we, addr, wdata in; gnt, rvalid, rdata out
//   sram_req_o           array access strobe
//   sram_write_o         array write select
//   sram_wmask_o         active-low write mask (0 enables the write)
//   sram_addr_o          array address
//   sram_wdata_o         array write data
//   sram_rdata_i         array read data, valid the cycle after a read strobe

module sram_arb_1p1024x39 #(
    parameter int unsigned     Depth     = 1024,
    parameter int unsigned     AddrWidth = 10,
    parameter int unsigned     Width     = 39,
    parameter logic [Width-1:0] InitValue = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 init_req_i,
    output logic                 init_done_o,

    input  logic                 a_req_i,
    input  logic                 a_we_i,
    input  logic [AddrWidth-1:0] a_addr_i,
    input  logic [Width-1:0]     a_wdata_i,
    output logic                 a_gnt_o,
    output logic                 a_rvalid_o,
    output logic [Width-1:0]     a_rdata_o,

    input  logic                 b_req_i,
    input  logic                 b_we_i,
    input  logic [AddrWidth-1:0] b_addr_i,
    input  logic [Width-1:0]     b_wdata_i,
    output logic                 b_gnt_o,
    output logic                 b_rvalid_o,
    output logic [Width-1:0]     b_rdata_o,

    output logic                 sram_req_o,
    output logic                 sram_write_o,
    output logic                 sram_wmask_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [Width-1:0]     sram_wdata_o,
    input  logic [Width-1:0]     sram_rdata_i
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    typedef enum logic [1:0] {
        StStart,
        StInit,
        StIdle
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d;
    // 1 means B was granted last, so A wins the next tie.
    logic                 rr_last_q, rr_last_d;
    logic                 init_done_q, init_done_d;
    logic                 a_rvalid_q, a_rvalid_d;
    logic                 b_rvalid_q, b_rvalid_d;

    logic                 a_gnt, b_gnt;

    // Next-state, arbitration and the SRAM drive.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_last_d    = rr_last_q;
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        sram_req_o   = 1'b0;
        sram_write_o = 1'b0;
        sram_wmask_o = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;

        unique case (state_q)
            // One quiet cycle after reset before the clear begins. All outputs stay at 0,
            // which keeps everything low while reset is held.
            StStart: begin
                state_d = StInit;
            end

            StInit: begin
                sram_req_o   = 1'b1;
                sram_write_o = 1'b1;
                sram_wmask_o = 1'b0;
                sram_addr_o  = cnt_q;
                sram_wdata_o = InitValue;
                if (cnt_q == LastAddr) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + AddrWidth'(1);
                end
            end

            StIdle: begin
                sram_wmask_o = 1'b1;
                if (init_req_i) begin
                    cnt_d   = '0;
                    state_d = StInit;
                end else begin
                    a_gnt = a_req_i & (~b_req_i | rr_last_q);
                    b_gnt = b_req_i & ~a_gnt;
                    if (a_gnt) begin
                        sram_req_o   = 1'b1;
                        sram_write_o = a_we_i;
                        sram_wmask_o = 1'b0;
                        sram_addr_o  = a_addr_i;
                        sram_wdata_o = a_wdata_i;
                        rr_last_d    = 1'b0;
                    end else if (b_gnt) begin
                        sram_req_o   = 1'b1;
                        sram_write_o = b_we_i;
                        sram_wmask_o = 1'b0;
                        sram_addr_o  = b_addr_i;
                        sram_wdata_o = b_wdata_i;
                        rr_last_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StStart;
            end
        endcase
    end

    // init_done is registered: it is high exactly while the state register holds IDLE.
    always_comb begin
        init_done_d = (state_d == StIdle);
        a_rvalid_d  = a_gnt & ~a_we_i;
        b_rvalid_d  = b_gnt & ~b_we_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StStart;
            cnt_q       <= '0;
            rr_last_q   <= 1'b1;
            init_done_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            init_done_q <= init_done_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
        end
    end

    assign init_done_o = init_done_q;
    assign a_gnt_o     = a_gnt;
    assign b_gnt_o     = b_gnt;
    assign a_rvalid_o  = a_rvalid_q;
    assign b_rvalid_o  = b_rvalid_q;
    // The array registers its read data itself, so it lines up with the rvalid flag.
    assign a_rdata_o   = a_rvalid_q ? sram_rdata_i : '0;
    assign b_rdata_o   = b_rvalid_q ? sram_rdata_i : '0;

endmodule

// File: tb/tb_sram_arb_1p1024x39.sv
`timescale 1ns / 1ps
module tb_sram_arb_1p1024x39;

    localparam int Depth = 1024;
    localparam int AW    = 10;
    localparam int W     = 39;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          init_req_i, init_done_o;
    logic          a_req_i, a_we_i, a_gnt_o, a_rvalid_o;
    logic [AW-1:0] a_addr_i;
    logic [W-1:0]  a_wdata_i, a_rdata_o;
    logic          b_req_i, b_we_i, b_gnt_o, b_rvalid_o;
    logic [AW-1:0] b_addr_i;
    logic [W-1:0]  b_wdata_i, b_rdata_o;
    logic          sram_req_o, sram_write_o, sram_wmask_o;
    logic [AW-1:0] sram_addr_o;
    logic [W-1:0]  sram_wdata_o, sram_rdata_i;

    always #5 clk_i = ~clk_i;

    sram_arb_1p1024x39 dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .init_req_i  (init_req_i),
        .init_done_o (init_done_o),
        .a_req_i     (a_req_i),
        .a_we_i      (a_we_i),
        .a_addr_i    (a_addr_i),
        .a_wdata_i   (a_wdata_i),
        .a_gnt_o     (a_gnt_o),
        .a_rvalid_o  (a_rvalid_o),
        .a_rdata_o   (a_rdata_o),
        .b_req_i     (b_req_i),
        .b_we_i      (b_we_i),
        .b_addr_i    (b_addr_i),
        .b_wdata_i   (b_wdata_i),
        .b_gnt_o     (b_gnt_o),
        .b_rvalid_o  (b_rvalid_o),
        .b_rdata_o   (b_rdata_o),
        .sram_req_o  (sram_req_o),
        .sram_write_o(sram_write_o),
        .sram_wmask_o(sram_wmask_o),
        .sram_addr_o (sram_addr_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    // Behavioural array with registered read; preloaded with junk so the clear is visible.
    logic [W-1:0] mem [Depth];
    initial begin
        logic [63:0] t;
        for (int i = 0; i < Depth; i++) begin
            t = {$urandom(), $urandom()};
            mem[i] <= t[W-1:0] | 39'h1;
        end
    end
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_write_o) begin
                if (!sram_wmask_o) mem[sram_addr_o] <= sram_wdata_o;
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] data;
        int           due;
    } exp_t;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    logic [W-1:0] ref_mem [Depth];
    logic         rr_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: pop an expected read each time an rvalid shows up.
    always @(negedge clk_i) begin
        if (a_rvalid_o) begin
            if (exp_a.size() == 0) begin
                check("a_rvalid_unexpected", 64'(1'b1), 64'd0);
            end else begin
                ea = exp_a.pop_front();
                check("a_rvalid_cycle", 64'(cyc), 64'(ea.due));
                check("a_rdata", 64'(a_rdata_o), 64'(ea.data));
            end
        end else begin
            if (a_rdata_o != '0) check("a_rdata_idle", 64'(a_rdata_o), 64'd0);
            if (exp_a.size() > 0 && exp_a[0].due <= cyc) begin
                check("a_rvalid_missing", 64'(1'b0), 64'(1'b1));
                void'(exp_a.pop_front());
            end
        end
        if (b_rvalid_o) begin
            if (exp_b.size() == 0) begin
                check("b_rvalid_unexpected", 64'(1'b1), 64'd0);
            end else begin
                eb = exp_b.pop_front();
                check("b_rvalid_cycle", 64'(cyc), 64'(eb.due));
                check("b_rdata", 64'(b_rdata_o), 64'(eb.data));
            end
        end else begin
            if (b_rdata_o != '0) check("b_rdata_idle", 64'(b_rdata_o), 64'd0);
            if (exp_b.size() > 0 && exp_b[0].due <= cyc) begin
                check("b_rvalid_missing", 64'(1'b0), 64'(1'b1));
                void'(exp_b.pop_front());
            end
        end
    end

    task automatic zero_ref();
        for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({sram_req_o, sram_write_o, sram_wmask_o, sram_addr_o, a_gnt_o,
                                 a_rvalid_o, b_gnt_o, b_rvalid_o, init_done_o}), 64'd0);
        check({tag, "_wdata"}, 64'(sram_wdata_o), 64'd0);
        check({tag, "_rdata"}, 64'(a_rdata_o | b_rdata_o), 64'd0);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        rr_b = 1'b1;
        zero_ref();
    endtask

    // Follows a clear; requests and init_req are held high to show they are ignored.
    task automatic clear_check(input logic with_start, input int abort_at);
        a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = 10'h155; a_wdata_i = 39'h1234;
        b_req_i = 1'b1; b_we_i = 1'b1; b_addr_i = 10'h2AA; b_wdata_i = 39'h4321;
        init_req_i = 1'b1;
        if (with_start) begin
            @(negedge clk_i);
            check("start_cycle", 64'({sram_req_o, sram_write_o, a_gnt_o, b_gnt_o, init_done_o}),
                  64'd0);
        end
        for (int i = 0; i < Depth; i++) begin
            @(negedge clk_i);
            check("clear_word", 64'({sram_req_o, sram_write_o, sram_wmask_o, sram_addr_o,
                                    sram_wdata_o, a_gnt_o, b_gnt_o, init_done_o}),
                  64'({1'b1, 1'b1, 1'b0, AW'(i), 39'h0, 1'b0, 1'b0, 1'b0}));
            if (i == abort_at) begin
                #2 rst_i = 1'b1;
                exp_a.delete();
                exp_b.delete();
                #1 check_zero("rst_mid_clear");
                return;
            end
        end
        a_req_i = 1'b0;
        b_req_i = 1'b0;
        init_req_i = 1'b0;
    endtask

    // Drive one cycle of stimulus and check the combinational response at the negedge.
    task automatic access(input logic init,
                          input logic ar, input logic aw, input logic [AW-1:0] aa,
                          input logic [W-1:0] ad,
                          input logic br, input logic bw, input logic [AW-1:0] ba,
                          input logic [W-1:0] bd,
                          output logic ga, output logic gb);
        logic [51:0] exp_drv;
        init_req_i = init;
        a_req_i = ar; a_we_i = aw; a_addr_i = aa; a_wdata_i = ad;
        b_req_i = br; b_we_i = bw; b_addr_i = ba; b_wdata_i = bd;
        @(negedge clk_i);
        ga = !init && ar && (!br || rr_b);
        gb = !init && br && !ga;
        check("a_gnt", 64'(a_gnt_o), 64'(ga));
        check("b_gnt", 64'(b_gnt_o), 64'(gb));
        check("init_done", 64'(init_done_o), 64'd1);
        if (ga)      exp_drv = {1'b1, aw, 1'b0, aa, ad};
        else if (gb) exp_drv = {1'b1, bw, 1'b0, ba, bd};
        else         exp_drv = {1'b0, 1'b0, 1'b1, 10'd0, 39'd0};
        check("sram_drive", 64'({sram_req_o, sram_write_o, sram_wmask_o, sram_addr_o,
                                sram_wdata_o}), 64'(exp_drv));
        if (ga) begin
            rr_b = 1'b0;
            if (aw) ref_mem[aa] = ad;
            else    exp_a.push_back('{data: ref_mem[aa], due: cyc + 1});
        end
        if (gb) begin
            rr_b = 1'b1;
            if (bw) ref_mem[ba] = bd;
            else    exp_b.push_back('{data: ref_mem[ba], due: cyc + 1});
        end
        if (init) zero_ref();
    endtask

    task automatic xfer(input logic init,
                        input logic ar, input logic aw, input logic [AW-1:0] aa,
                        input logic [W-1:0] ad,
                        input logic br, input logic bw, input logic [AW-1:0] ba,
                        input logic [W-1:0] bd,
                        output logic ga, output logic gb);
        access(init, ar, aw, aa, ad, br, bw, ba, bd, ga, gb);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        logic ga, gb;
        for (int i = 0; i < n; i++) xfer(0, 0, 0, '0, '0, 0, 0, '0, '0, ga, gb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        ga, gb;
        logic        par, paw, pbr, pbw;
        logic [AW-1:0] paa, pba;
        logic [W-1:0]  pad, pbd;
        logic [63:0] t;

        rst_i = 1'b1; init_req_i = 1'b0; rr_b = 1'b1;
        a_req_i = 0; a_we_i = 0; a_addr_i = '0; a_wdata_i = '0;
        b_req_i = 0; b_we_i = 0; b_addr_i = '0; b_wdata_i = '0;
        @(posedge clk_i);
        #1 check_zero("rst_initial");
        release_reset();
        clear_check(1, -1);

        // Both sides read continuously from the first idle cycle: A,B,A,B...
        for (int i = 0; i < 8; i++) xfer(0, 1, 0, AW'(i), '0, 1, 0, AW'(i + 100), '0, ga, gb);

        // A writes the top word then reads it back.
        xfer(0, 1, 1, 10'h3FF, 39'h5A5A5A5A5A, 0, 0, '0, '0, ga, gb);
        xfer(0, 1, 0, 10'h3FF, '0, 0, 0, '0, '0, ga, gb);
        idle(1);

        // B alone for three cycles, then both: A must win.
        for (int i = 1; i <= 3; i++) xfer(0, 0, 0, '0, '0, 1, 1, AW'(i), W'(i * 7 + 1), ga, gb);
        xfer(0, 1, 0, 10'h3FF, '0, 1, 0, 10'd2, '0, ga, gb);
        xfer(0, 0, 0, '0, '0, 1, 0, 10'd2, '0, ga, gb);
        idle(1);

        // Random mixed traffic over a few addresses; losers hold their request.
        par = 0; pbr = 0; paw = 0; pbw = 0; paa = '0; pba = '0; pad = '0; pbd = '0;
        for (int k = 0; k < 60; k++) begin
            if (!par) begin
                par = 1'($urandom_range(0, 1)); paw = 1'($urandom_range(0, 1));
                paa = AW'($urandom_range(0, 7)); t = {$urandom(), $urandom()}; pad = t[W-1:0];
            end
            if (!pbr) begin
                pbr = 1'($urandom_range(0, 1)); pbw = 1'($urandom_range(0, 1));
                pba = AW'($urandom_range(0, 7)); t = {$urandom(), $urandom()}; pbd = t[W-1:0];
            end
            xfer(0, par, paw, paa, pad, pbr, pbw, pba, pbd, ga, gb);
            if (ga) par = 0;
            if (gb) pbr = 0;
        end
        idle(2);

        // Read granted right before an init request still returns; then a full clear.
        xfer(0, 1, 0, 10'h3FF, '0, 0, 0, '0, '0, ga, gb);
        xfer(1, 1, 0, 10'h3FF, '0, 1, 0, 10'd1, '0, ga, gb);
        clear_check(0, -1);
        xfer(0, 1, 0, 10'h3FF, '0, 1, 0, 10'd2, '0, ga, gb);
        xfer(0, 0, 0, '0, '0, 1, 0, 10'd2, '0, ga, gb);
        xfer(0, 1, 0, 10'd3, '0, 0, 0, '0, '0, ga, gb);
        idle(1);

        // Reset while a read is in flight: no rvalid may follow.
        xfer(0, 1, 1, 10'd5, 39'h7F00FF00AA, 0, 0, '0, '0, ga, gb);
        access(0, 1, 0, 10'd5, '0, 0, 0, '0, '0, ga, gb);
        #1 rst_i = 1'b1;
        exp_a.delete();
        exp_b.delete();
        #1 check_zero("rst_mid_read");
        release_reset();

        // Reset again in the middle of the clear; it restarts from address 0.
        clear_check(1, 500);
        release_reset();
        clear_check(1, -1);
        xfer(0, 1, 0, 10'd5, '0, 1, 0, 10'd500, '0, ga, gb);
        xfer(0, 0, 0, '0, '0, 1, 0, 10'd500, '0, ga, gb);
        idle(3);

        check("a_queue_drained", 64'(exp_a.size()), 64'd0);
        check("b_queue_drained", 64'(exp_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
